relay_bank_sequencer: RTL and testbench

//  Break-before-make sequencer for a bank of N relay/switch coils (Relais/Switch devices).

---
 rtl/relay_bank_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_relay_bank_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/relay_bank_sequencer.sv
// relay_bank_sequencer
//    Break-before-make sequencer for a bank of N relay/switch coils. A
//    requested contact pattern is applied one coil per step: every coil that
//    has to open is handled before any coil that has to close. Each coil
//    change is followed by a settle dwell of SETTLE cycles.
//
//    Build option: RELAY_SENSE_EN adds contact feedback checking.
//
// Ports
//    clk        in   1  clock, rising edge
//    rst_n      in   1  asynchronous active-low reset
//    req_valid  in   1  target pattern valid
//    req_ready  out  1  high only in IDLE
//    req_mask   in   N  target coil state, 1 = closed
//    drv        out  N  coil drive, 1 = energised
//    busy       out  1  high in every state except IDLE
//    done       out  1  one-cycle pulse at end of sequence
//    sense      in   N  synchronised contact feedback (RELAY_SENSE_EN only)
//    fault      out  1  sticky contact mismatch (constant 0 without RELAY_SENSE_EN)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// BREAK | open the lowest coil that is on but not wanted, else go MAKE
// BWAIT | settle dwell after an opening
// MAKE  | close the lowest coil that is wanted but off, else go DONE
// MWAIT | settle dwell after a closing
// DONE  | done pulse for one cycle

module relay_bank_sequencer #(
   parameter int N      = 4,
   parameter int SETTLE = 1000,
   parameter int CW     = $clog2(SETTLE + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] req_mask,
   output logic [N-1:0] drv,
   output logic         busy,
   output logic         done,
`ifdef RELAY_SENSE_EN
   input  logic [N-1:0] sense,
`endif
   output logic         fault
);

   if (SETTLE < 1) begin : g_settle_check
      $error("relay_bank_sequencer: SETTLE must be >= 1");
   end

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_BREAK = 3'd1;
   localparam logic [2:0] S_BWAIT = 3'd2;
   localparam logic [2:0] S_MAKE  = 3'd3;
   localparam logic [2:0] S_MWAIT = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [N-1:0]  drv_q, drv_d;
   logic [N-1:0]  tgt_q, tgt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N-1:0]  brk_vec, mk_vec;
   logic [IW-1:0] brk_idx, mk_idx;

   assign brk_vec = drv_q & ~tgt_q;
   assign mk_vec  = ~drv_q & tgt_q;

   // Descending scan so the lowest set bit is the one left standing.
   always_comb begin
      brk_idx = '0;
      mk_idx  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (brk_vec[i]) brk_idx = IW'(i);
         if (mk_vec[i])  mk_idx  = IW'(i);
      end
   end

`ifdef RELAY_SENSE_EN
   logic          fault_q, fault_d;
   logic [IW-1:0] sw_idx_q, sw_idx_d;
`endif

   always_comb begin
      state_d = state_q;
      drv_d   = drv_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
`ifdef RELAY_SENSE_EN
      fault_d  = fault_q;
      sw_idx_d = sw_idx_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               tgt_d   = req_mask;
               state_d = S_BREAK;
`ifdef RELAY_SENSE_EN
               fault_d = 1'b0;
`endif
            end
         end
         S_BREAK: begin
            if (|brk_vec) begin
               drv_d[brk_idx] = 1'b0;
               cnt_d          = CW'(SETTLE);
               state_d        = S_BWAIT;
`ifdef RELAY_SENSE_EN
               sw_idx_d       = brk_idx;
`endif
            end else begin
               state_d = S_MAKE;
            end
         end
         S_MAKE: begin
            if (|mk_vec) begin
               drv_d[mk_idx] = 1'b1;
               cnt_d         = CW'(SETTLE);
               state_d       = S_MWAIT;
`ifdef RELAY_SENSE_EN
               sw_idx_d      = mk_idx;
`endif
            end else begin
               state_d = S_DONE;
            end
         end
         S_BWAIT, S_MWAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = (state_q == S_BWAIT) ? S_BREAK : S_MAKE;
`ifdef RELAY_SENSE_EN
               // Contact should have followed its coil by the end of the dwell.
               if (sense[sw_idx_q] != drv_q[sw_idx_q]) begin
                  fault_d = 1'b1;
                  drv_d   = '0;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            drv_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         drv_q   <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         drv_q   <= drv_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef RELAY_SENSE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q  <= 1'b0;
         sw_idx_q <= '0;
      end else begin
         fault_q  <= fault_d;
         sw_idx_q <= sw_idx_d;
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign drv       = drv_q;
   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_relay_bank_sequencer.sv
module tb_relay_bank_sequencer;

   localparam int N      = 4;
   localparam int SETTLE = 4;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [N-1:0] req_mask;
   logic [N-1:0] drv;
   logic         busy;
   logic         done;
   logic         fault;
`ifdef RELAY_SENSE_EN
   logic [N-1:0] sense;
   logic         sense_stuck;
   assign sense = sense_stuck ? '0 : drv;
`endif

   relay_bank_sequencer #(.N(N), .SETTLE(SETTLE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mask  (req_mask),
      .drv       (drv),
      .busy      (busy),
      .done      (done),
`ifdef RELAY_SENSE_EN
      .sense     (sense),
`endif
      .fault     (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests;
   int failed;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] exp_drv;
      int           exp_first;   // edge of first drv change, 0 = none
      int           exp_done;    // edge after which done is high
   } vec_t;

   vec_t vecs[8];
   logic [N-1:0] cur_drv;

   // Apply one request and follow it to its done pulse.
   task automatic run_req(input vec_t v, input string tag);
      logic [N-1:0] prev;
      int done_edge, first_edge;
      bit ok;
      check({tag, " ready_before"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_mask  = v.req;
      tick();
      req_valid = 1'b0;
      req_mask  = ~v.req;
      prev = cur_drv;
      done_edge = 0;
      first_edge = 0;
      ok = 1'b1;
      for (int e = 1; e <= 60 && done_edge == 0; e++) begin
         tick();
         if (drv !== prev) begin
            if (first_edge == 0) first_edge = e;
            if ($countones(drv ^ prev) != 1) ok = 1'b0;
         end
         if ((drv & ~(cur_drv | v.req)) != '0) ok = 1'b0;
         if (((drv & v.req & ~cur_drv) != '0) && ((drv & cur_drv & ~v.req) != '0)) ok = 1'b0;
         if (busy !== 1'b1 || req_ready !== 1'b0) ok = 1'b0;
         if (done === 1'b1) done_edge = e;
         prev = drv;
      end
      check({tag, " done_edge"}, done_edge, v.exp_done);
      check({tag, " first_change"}, first_edge, v.exp_first);
      check({tag, " final_drv"}, {28'd0, drv}, {28'd0, v.exp_drv});
      check({tag, " bbm_seq"}, {31'd0, ok}, 32'd1);
      tick();
      check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
      cur_drv = v.exp_drv;
   endtask

   initial begin
      tests = 0;
      failed = 0;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_mask = '0;
      cur_drv = '0;
`ifdef RELAY_SENSE_EN
      sense_stuck = 1'b0;
`endif
      vecs[0] = '{4'b0011, 4'b0011, 2, 12};
      vecs[1] = '{4'b0110, 4'b0110, 1, 12};
      vecs[2] = '{4'b0101, 4'b0101, 1, 12};
      vecs[3] = '{4'b0101, 4'b0101, 0, 2};
      vecs[4] = '{4'b1111, 4'b1111, 2, 12};
      vecs[5] = '{4'b0000, 4'b0000, 1, 22};
      vecs[6] = '{4'b1000, 4'b1000, 2, 7};
      vecs[7] = '{4'b0111, 4'b0111, 1, 22};

      #12;
      check("rst drv", {28'd0, drv}, 32'd0);
      check("rst ready", {31'd0, req_ready}, 32'd1);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst fault", {31'd0, fault}, 32'd0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of a break dwell with drv=0011.
      req_valid = 1'b1;
      req_mask  = 4'b0011;
      tick();
      req_valid = 1'b0;
      tick();
      check("midrst drv_before", {28'd0, drv}, 32'h3);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst drv_async", {28'd0, drv}, 32'h0);
      check("midrst busy", {31'd0, busy}, 32'd0);
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      check("midrst ready", {31'd0, req_ready}, 32'd1);
      check("midrst drv_after", {28'd0, drv}, 32'h0);
      check("midrst done", {31'd0, done}, 32'd0);
      cur_drv = '0;

      // Request held through busy with a different mask.
      begin
         bit ign_ok;
         int done_edge;
         req_valid = 1'b1;
         req_mask  = 4'b0001;
         tick();
         req_mask  = 4'b1110;
         ign_ok = 1'b1;
         done_edge = 0;
         for (int e = 1; e <= 40 && done_edge == 0; e++) begin
            tick();
            if (req_ready !== 1'b0) ign_ok = 1'b0;
            if (drv[3:1] !== 3'b000) ign_ok = 1'b0;
            if (done === 1'b1) done_edge = e;
         end
         check("hold done_edge", done_edge, 7);
         check("hold ignored", {31'd0, ign_ok}, 32'd1);
         check("hold drv", {28'd0, drv}, 32'h1);
         tick();
         check("hold ready_after_done", {31'd0, req_ready}, 32'd1);
         tick();
         req_valid = 1'b0;
         check("hold accepted_busy", {31'd0, busy}, 32'd1);
         check("hold accepted_ready", {31'd0, req_ready}, 32'd0);
         done_edge = 0;
         for (int e = 1; e <= 60 && done_edge == 0; e++) begin
            tick();
            if (done === 1'b1) done_edge = e;
         end
         check("hold second_done", done_edge, 22);
         check("hold second_drv", {28'd0, drv}, 32'hE);
         tick();
         cur_drv = 4'b1110;
      end

`ifdef RELAY_SENSE_EN
      run_req('{4'b0000, 4'b0000, 1, 17}, "sense_clear");
      sense_stuck = 1'b1;
      begin
         int done_edge;
         req_valid = 1'b1;
         req_mask  = 4'b0001;
         tick();
         req_valid = 1'b0;
         done_edge = 0;
         for (int e = 1; e <= 40 && done_edge == 0; e++) begin
            tick();
            if (done === 1'b1) done_edge = e;
         end
         check("sense done_edge", done_edge, 6);
         check("sense fault", {31'd0, fault}, 32'd1);
         check("sense drv", {28'd0, drv}, 32'h0);
         tick();
         check("sense fault_sticky", {31'd0, fault}, 32'd1);
         sense_stuck = 1'b0;
         req_valid = 1'b1;
         req_mask  = 4'b0000;
         tick();
         req_valid = 1'b0;
         check("sense fault_cleared", {31'd0, fault}, 32'd0);
         repeat (4) tick();
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
